// File: rtl/prog_parser_pkg.sv
// Shared types, constants and field layouts for the programmable header parser.
package prog_parser_pkg;

   localparam int NUM_HDRS  = 4;
   localparam int NXT_ENT   = 4;
   localparam int TAG_W     = 16;
   localparam int OFF_W     = 16;
   localparam int ID_W      = $clog2(NUM_HDRS);
   localparam int SEL_W     = $clog2(NXT_ENT + 1);
   localparam int ENT_IDX_W = $clog2(NXT_ENT);
   localparam int LEN_W     = 8;

   // Offset reported for a header that was not found.
   localparam logic [OFF_W-1:0] NO_OFFSET = '1;

   // cfg_sel value addressing the header descriptor; k addresses entry k-1.
   localparam logic [SEL_W-1:0] CFG_SEL_DESC = '0;

   // Descriptor layout: {len[7:0], tag_start[7:0], tag_len[1:0]}.
   localparam int DESC_TLEN_LSB   = 0;
   localparam int DESC_TSTART_LSB = 2;
   localparam int DESC_LEN_LSB    = 10;
   localparam int DESC_W          = DESC_LEN_LSB + LEN_W;

   // Next-table entry layout: {valid, tag[15:0], next_id}.
   localparam int ENT_ID_LSB    = 0;
   localparam int ENT_TAG_LSB   = ID_W;
   localparam int ENT_VALID_BIT = ID_W + TAG_W;

   // Config bits carrying information; anything above is reserved.
   localparam int CFG_PAYLOAD_W = ENT_VALID_BIT + 1;

   // Every memory read fetches one 32-bit big-endian word.
   localparam logic [3:0] MEM_WIDTH = 4'd4;

   typedef enum logic [2:0] {
      PP_ST_IDLE  = 3'd0,
      PP_ST_REQ   = 3'd1,
      PP_ST_WAIT  = 3'd2,
      PP_ST_MATCH = 3'd3,
      PP_ST_DONE  = 3'd4
   } pp_state_e;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [7:0]       tag_start;
      logic [1:0]       tag_len;
   } hdr_desc_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [ID_W-1:0]  next_id;
   } nxt_ent_t;

   function automatic hdr_desc_t unpack_desc(input logic [DESC_W-1:0] d);
      hdr_desc_t r;
      r.len       = d[DESC_LEN_LSB +: LEN_W];
      r.tag_start = d[DESC_TSTART_LSB +: 8];
      r.tag_len   = d[DESC_TLEN_LSB +: 2];
      return r;
   endfunction

   function automatic nxt_ent_t unpack_ent(input logic [CFG_PAYLOAD_W-1:0] d);
      nxt_ent_t r;
      r.valid   = d[ENT_VALID_BIT];
      r.tag     = d[ENT_TAG_LSB +: TAG_W];
      r.next_id = d[ENT_ID_LSB +: ID_W];
      return r;
   endfunction

   // Top TAG_W bits of the fetched word, cut down to tag_len bytes and
   // zero-extended. A length of 3 is treated as the 2-byte maximum.
   function automatic logic [TAG_W-1:0] extract_tag(input logic [TAG_W-1:0] w,
                                                    input logic [1:0]       tag_len);
      logic [TAG_W-1:0] t;
      case (tag_len)
         2'd0:    t = '0;
         2'd1:    t = TAG_W'(w[TAG_W-1 -: 8]);
         default: t = w;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/prog_parser_tbl.sv
// Parse-graph table: per-header descriptor and next-header entries, the
// config write port, and the combinational lowest-index tag match.
module prog_parser_tbl
   import prog_parser_pkg::*;
(
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [ID_W-1:0]          wr_hdr,
   input  logic [SEL_W-1:0]         wr_sel,
   input  logic [CFG_PAYLOAD_W-1:0] wr_data,
   input  logic [ID_W-1:0]          cur_id,
   input  logic [TAG_W-1:0]         tag_word,
   output logic [7:0]               tag_start,
   output logic [LEN_W-1:0]         len,
   output logic                     hit,
   output logic [ID_W-1:0]          next_id
);

   hdr_desc_t desc_q [NUM_HDRS];
   nxt_ent_t  ent_q  [NUM_HDRS][NXT_ENT];

   logic [SEL_W-1:0]     sel_m1;
   logic [ENT_IDX_W-1:0] ent_idx;
   hdr_desc_t            cur_desc;
   logic [TAG_W-1:0]     tag;

   assign sel_m1  = wr_sel - SEL_W'(1);
   assign ent_idx = sel_m1[ENT_IDX_W-1:0];

   // Config write: one descriptor or one entry per strobe; out-of-range selects are dropped.
   // NOTE: the table has no reset on purpose -- its contents are owned by software and survive rst.
   // NOTE: sequential state is written with <= only, so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_sel == CFG_SEL_DESC) begin
            desc_q[wr_hdr] <= unpack_desc(wr_data[DESC_W-1:0]);
         end else if (wr_sel <= SEL_W'(NXT_ENT)) begin
            ent_q[wr_hdr][ent_idx] <= unpack_ent(wr_data);
         end
      end
   end

   // Descriptor lookup and priority match; scanning downwards lets the lowest index win.
   // NOTE: every output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      cur_desc  = desc_q[cur_id];
      tag_start = cur_desc.tag_start;
      len       = cur_desc.len;
      tag       = extract_tag(tag_word, cur_desc.tag_len);
      hit       = 1'b0;
      next_id   = '0;
      for (int e = NXT_ENT - 1; e >= 0; e--) begin
         if (ent_q[cur_id][e].valid && (ent_q[cur_id][e].tag == tag)) begin
            hit     = 1'b1;
            next_id = ent_q[cur_id][e].next_id;
         end
      end
      // A zero-length tag marks a terminal header: it never matches.
      if (cur_desc.tag_len == 2'd0) begin
         hit = 1'b0;
      end
   end

endmodule

// File: rtl/prog_parser.sv
// Runtime-programmable header parser: follows the configured parse graph
// through packet memory and reports the byte offset of each header found.
module prog_parser
   import prog_parser_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      cfg_we_i,
   input  logic [ID_W-1:0]           cfg_hdr_i,
   input  logic [SEL_W-1:0]          cfg_sel_i,
   input  logic [31:0]               cfg_data_i,
   output logic                      cfg_busy_o,
   output logic                      mem_ce_o,
   output logic [OFF_W-1:0]          mem_addr_o,
   output logic [3:0]                mem_width_o,
   input  logic [31:0]               mem_data_i,
   input  logic                      mem_valid_i,
   output logic                      ready_o,
   output logic                      err_o,
   output logic [NUM_HDRS-1:0]       hdr_vld_o,
   output logic [NUM_HDRS*OFF_W-1:0] offsets_o
);

   pp_state_e                 state_q, state_d;
   logic [ID_W-1:0]           cur_q, cur_d;
   logic [OFF_W-1:0]          base_q, base_d;
   logic [TAG_W-1:0]          data_q, data_d;
   logic [NUM_HDRS-1:0]       vld_q, vld_d;
   logic [NUM_HDRS*OFF_W-1:0] off_q, off_d;
   logic                      err_q, err_d;

   logic [OFF_W:0]            base_sum;
   logic [NUM_HDRS-1:0]       vld_mark;

   logic [7:0]                tbl_tag_start;
   logic [LEN_W-1:0]          tbl_len;
   logic                      tbl_hit;
   logic [ID_W-1:0]           tbl_next_id;

   // Reserved config bits and the word's low bytes carry nothing the parser needs.
   logic unused_bits;
   assign unused_bits = ^{cfg_data_i[31:CFG_PAYLOAD_W], mem_data_i[31-TAG_W:0]};

   // Writes are accepted only while idle so the graph cannot change under a parse.
   prog_parser_tbl u_tbl (
      .clk       (clk),
      .wr_en     (cfg_we_i && (state_q == PP_ST_IDLE)),
      .wr_hdr    (cfg_hdr_i),
      .wr_sel    (cfg_sel_i),
      .wr_data   (cfg_data_i[CFG_PAYLOAD_W-1:0]),
      .cur_id    (cur_q),
      .tag_word  (data_q),
      .tag_start (tbl_tag_start),
      .len       (tbl_len),
      .hit       (tbl_hit),
      .next_id   (tbl_next_id)
   );

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PP_ST_IDLE;
         cur_q   <= '0;
         base_q  <= '0;
         data_q  <= '0;
         vld_q   <= '0;
         off_q   <= {NUM_HDRS{NO_OFFSET}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         base_q  <= base_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         off_q   <= off_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath updates for the parse walk.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      base_d   = base_q;
      data_d   = data_q;
      vld_d    = vld_q;
      off_d    = off_q;
      err_d    = err_q;
      // One bit wider than the offset so a carry flags an overflowing header.
      base_sum = {1'b0, base_q} + (OFF_W + 1)'(tbl_len);
      // Marking the current header first makes a self-loop look like any other loop.
      vld_mark = vld_q | (NUM_HDRS'(1) << cur_q);

      case (state_q)
         PP_ST_IDLE: begin
            if (start_i) begin
               vld_d   = '0;
               off_d   = {NUM_HDRS{NO_OFFSET}};
               err_d   = 1'b0;
               cur_d   = '0;
               base_d  = '0;
               state_d = PP_ST_REQ;
            end
         end
         PP_ST_REQ: begin
            state_d = PP_ST_WAIT;
         end
         PP_ST_WAIT: begin
            if (mem_valid_i) begin
               data_d  = mem_data_i[31 -: TAG_W];
               state_d = PP_ST_MATCH;
            end
         end
         PP_ST_MATCH: begin
            vld_d                        = vld_mark;
            off_d[cur_q*OFF_W +: OFF_W]  = base_q;
            if (!tbl_hit) begin
               state_d = PP_ST_DONE;
            end else if (vld_mark[tbl_next_id] || base_sum[OFF_W]) begin
               err_d   = 1'b1;
               state_d = PP_ST_DONE;
            end else begin
               base_d  = base_sum[OFF_W-1:0];
               cur_d   = tbl_next_id;
               state_d = PP_ST_REQ;
            end
         end
         PP_ST_DONE: begin
            if (!start_i) begin
               state_d = PP_ST_IDLE;
            end
         end
         default: begin
            state_d = PP_ST_IDLE;
         end
      endcase
   end

   // The address is only driven while requesting so the bus idles at zero.
   assign mem_ce_o    = (state_q == PP_ST_REQ);
   assign mem_addr_o  = mem_ce_o ? (base_q + OFF_W'(tbl_tag_start)) : '0;
   assign mem_width_o = MEM_WIDTH;
   assign ready_o     = (state_q == PP_ST_DONE);
   assign cfg_busy_o  = (state_q != PP_ST_IDLE);
   assign err_o       = err_q;
   assign hdr_vld_o   = vld_q;
   assign offsets_o   = off_q;

endmodule

// File: tb/tb_prog_parser.sv
// Bench for prog_parser: directed protocol scenarios plus randomized parse
// graphs checked against a behavioural walk of the graph over a byte array.
module tb_prog_parser;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        cfg_we_i;
   logic [1:0]  cfg_hdr_i;
   logic [2:0]  cfg_sel_i;
   logic [31:0] cfg_data_i;
   logic        cfg_busy_o;
   logic        mem_ce_o;
   logic [15:0] mem_addr_o;
   logic [3:0]  mem_width_o;
   logic [31:0] mem_data_i;
   logic        mem_valid_i;
   logic        ready_o;
   logic        err_o;
   logic [3:0]  hdr_vld_o;
   logic [63:0] offsets_o;

   int total = 0;
   int bad   = 0;
   int mem_lat;

   logic [7:0] pkt [0:65535];

   // Model copy of the parse graph, updated only by accepted config writes.
   int m_len  [4];
   int m_ts   [4];
   int m_tl   [4];
   int m_ev   [4][4];
   int m_etag [4][4];
   int m_eid  [4][4];

   prog_parser dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_hdr_i   (cfg_hdr_i),
      .cfg_sel_i   (cfg_sel_i),
      .cfg_data_i  (cfg_data_i),
      .cfg_busy_o  (cfg_busy_o),
      .mem_ce_o    (mem_ce_o),
      .mem_addr_o  (mem_addr_o),
      .mem_width_o (mem_width_o),
      .mem_data_i  (mem_data_i),
      .mem_valid_i (mem_valid_i),
      .ready_o     (ready_o),
      .err_o       (err_o),
      .hdr_vld_o   (hdr_vld_o),
      .offsets_o   (offsets_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory responder: valid arrives mem_lat cycles after the request cycle.
   initial begin : responder
      bit          pend;
      int          cnt;
      logic [15:0] addr;
      pend        = 1'b0;
      cnt         = 0;
      addr        = '0;
      mem_valid_i = 1'b0;
      mem_data_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_valid_i = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt <= 0) begin
                  mem_valid_i = 1'b1;
                  mem_data_i  = {pkt[addr], pkt[addr + 16'd1], pkt[addr + 16'd2], pkt[addr + 16'd3]};
                  pend        = 1'b0;
               end
            end
            if (mem_ce_o) begin
               pend = 1'b1;
               cnt  = mem_lat;
               addr = mem_addr_o;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All drive tasks start and end one time unit after a rising edge.
   task automatic cfg_write(input int h, input int sel, input logic [31:0] d);
      cfg_we_i   = 1'b1;
      cfg_hdr_i  = 2'(h);
      cfg_sel_i  = 3'(sel);
      cfg_data_i = d;
      @(posedge clk);
      #1;
      cfg_we_i   = 1'b0;
   endtask

   task automatic cfg_desc(input int h, input int len, input int ts, input int tl);
      cfg_write(h, 0, 32'({8'(len), 8'(ts), 2'(tl)}));
      m_len[h] = len;
      m_ts[h]  = ts;
      m_tl[h]  = tl;
   endtask

   task automatic cfg_ent(input int h, input int e, input int v, input int tg, input int nid);
      cfg_write(h, e + 1, 32'({1'(v), 16'(tg), 2'(nid)}));
      m_ev[h][e]   = v;
      m_etag[h][e] = tg;
      m_eid[h][e]  = nid;
   endtask

   task automatic cfg_clear();
      for (int h = 0; h < 4; h++) begin
         cfg_desc(h, 0, 0, 0);
         for (int e = 0; e < 4; e++) cfg_ent(h, e, 0, 0, 0);
      end
   endtask

   // Walks the graph over pkt: record, read tag bytes, take first matching entry.
   task automatic model_parse(output logic [3:0] e_vld, output logic [63:0] e_off,
                              output logic e_err, output int e_n);
      int cur, base, addr, tg, nid;
      bit done, hit;
      e_vld = '0;
      e_off = '1;
      e_err = 1'b0;
      e_n   = 0;
      cur   = 0;
      base  = 0;
      nid   = 0;
      done  = 1'b0;
      while (!done && e_n < 16) begin
         e_n++;
         e_off[cur*16 +: 16] = base[15:0];
         e_vld[cur] = 1'b1;
         if (m_tl[cur] == 0) begin
            done = 1'b1;
         end else begin
            addr = (base + m_ts[cur]) % 65536;
            if (m_tl[cur] == 1) tg = int'(pkt[addr]);
            else tg = int'(pkt[addr]) * 256 + int'(pkt[(addr + 1) % 65536]);
            hit = 1'b0;
            for (int e = 0; e < 4; e++) begin
               if (!hit && m_ev[cur][e] != 0 && m_etag[cur][e] == tg) begin
                  hit = 1'b1;
                  nid = m_eid[cur][e];
               end
            end
            if (!hit) begin
               done = 1'b1;
            end else if (e_vld[nid] || (base + m_len[cur] > 65535)) begin
               e_err = 1'b1;
               done  = 1'b1;
            end else begin
               base += m_len[cur];
               cur   = nid;
            end
         end
      end
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!ready_o && cyc < 2000);
      check("ready_seen", ready_o, 1);
   endtask

   task automatic run_parse(input int lat, output int cyc, output int n);
      logic [3:0]  ev;
      logic [63:0] eo;
      logic        ee;
      mem_lat = lat;
      model_parse(ev, eo, ee, n);
      start_i = 1'b1;
      wait_ready(cyc);
      check("hdr_vld", hdr_vld_o, ev);
      check("offsets", offsets_o, eo);
      check("err", err_o, ee);
      check("busy_in_done", cfg_busy_o, 1);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("ready_clear", ready_o, 0);
      check("back_idle", cfg_busy_o, 0);
      check("hold_vld", hdr_vld_o, ev);
   endtask

   task automatic wait_ce();
      int k;
      k = 0;
      while (!mem_ce_o && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ce_seen", mem_ce_o, 1);
   endtask

   task automatic eth_ipv4_cfg();
      cfg_clear();
      cfg_desc(0, 14, 12, 2);
      cfg_ent(0, 0, 1, 16'h0800, 1);
      cfg_desc(1, 20, 0, 0);
   endtask

   initial begin : main
      int cyc1, cyc4, n, cyc_x;
      rst        = 1'b1;
      start_i    = 1'b0;
      cfg_we_i   = 1'b0;
      cfg_hdr_i  = '0;
      cfg_sel_i  = '0;
      cfg_data_i = '0;
      mem_lat    = 1;
      for (int a = 0; a < 65536; a++) pkt[a] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values.
      check("rst_ready", ready_o, 0);
      check("rst_err", err_o, 0);
      check("rst_vld", hdr_vld_o, 0);
      check("rst_off", offsets_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rst_ce", mem_ce_o, 0);
      check("rst_busy", cfg_busy_o, 0);
      check("rst_width", mem_width_o, 4);

      // Ethernet followed by IPv4, memory latency 1 then 4.
      eth_ipv4_cfg();
      pkt[12] = 8'h08;
      pkt[13] = 8'h00;
      run_parse(1, cyc1, n);
      check("eth_vld", hdr_vld_o, 4'b0011);
      check("eth_off", offsets_o, 64'hFFFF_FFFF_000E_0000);
      run_parse(4, cyc4, n);
      check("eth_vld_l4", hdr_vld_o, 4'b0011);
      check("lat_delta", 64'(cyc4 - cyc1), 64'(3 * n));

      // IPv6 ethertype: no entry matches.
      pkt[12] = 8'h86;
      pkt[13] = 8'hDD;
      run_parse(2, cyc_x, n);
      check("v6_vld", hdr_vld_o, 4'b0001);
      check("v6_off1", offsets_o[31:16], 16'hFFFF);
      check("v6_err", err_o, 0);

      // Loop back to the root header.
      pkt[12] = 8'h08;
      pkt[13] = 8'h00;
      pkt[23] = 8'h06;
      cfg_desc(1, 20, 9, 1);
      cfg_ent(1, 0, 1, 16'h0006, 0);
      run_parse(3, cyc_x, n);
      check("loop_err", err_o, 1);
      check("loop_vld", hdr_vld_o, 4'b0011);

      // Config strobe while waiting on memory must be ignored.
      eth_ipv4_cfg();
      mem_lat = 6;
      start_i = 1'b1;
      wait_ce();
      @(posedge clk);
      #1;
      check("busy_wait", cfg_busy_o, 1);
      cfg_we_i   = 1'b1;
      cfg_hdr_i  = 2'd0;
      cfg_sel_i  = 3'd0;
      cfg_data_i = 32'({8'd14, 8'd12, 2'd0});
      @(posedge clk);
      #1;
      cfg_we_i = 1'b0;
      wait_ready(cyc_x);
      check("we_wait_vld", hdr_vld_o, 4'b0011);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      run_parse(1, cyc_x, n);
      check("after_we_off", offsets_o, 64'hFFFF_FFFF_000E_0000);

      // Reset while waiting on memory.
      mem_lat = 6;
      start_i = 1'b1;
      wait_ce();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy", cfg_busy_o, 0);
      check("midrst_ce", mem_ce_o, 0);
      check("midrst_ready", ready_o, 0);
      check("midrst_off", offsets_o, 64'hFFFF_FFFF_FFFF_FFFF);
      check("midrst_vld", hdr_vld_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_parse(2, cyc_x, n);
      check("post_rst_vld", hdr_vld_o, 4'b0011);

      // Randomized graphs and packets.
      for (int it = 0; it < 40; it++) begin
         for (int a = 0; a < 1400; a++) pkt[a] = 8'($urandom_range(0, 3));
         for (int h = 0; h < 4; h++) begin
            cfg_desc(h, int'($urandom_range(1, 64)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2)));
            for (int e = 0; e < 4; e++) begin
               cfg_ent(h, e, int'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                                   : int'($urandom_range(0, 3) * 256 + $urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            end
         end
         run_parse(int'($urandom_range(1, 5)), cyc_x, n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
